// File: rtl/ipd_stage_pkg.sv
// Shared widths, flag bit positions and opcode constants for the IPD stage.
package ipd_stage_pkg;
  localparam int IF_TO_IPD_BUS_WD = 64;
  localparam int IPD_TO_ID_BUS_WD = 104;

  localparam int PD_ADEF      = 0;
  localparam int PD_IS_BRANCH = 1;
  localparam int PD_IS_JIRL   = 2;
  localparam int PD_IS_BL     = 3;
  localparam int PD_IS_LD_W   = 4;
  localparam int PD_IS_ST_W   = 5;
  localparam int PD_WR_RD     = 6;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [9:0] OP_LD_W = 10'h0A2;
  localparam logic [9:0] OP_ST_W = 10'h0A6;

  typedef struct packed {
    logic [31:0] pred_pc;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic [7:0]  pd_flags;
  } ipd_to_id_t;
endpackage

// File: rtl/ipd_predecode.sv
// Combinational pre-decode of one instruction word; shared with the branch predictor.
module ipd_predecode
  import ipd_stage_pkg::*;
#(
  parameter logic [5:0] BR_OP_LO = 6'h13,
  parameter logic [5:0] BR_OP_HI = 6'h1B
) (
  input  logic [31:0] inst,
  input  logic [31:0] inst_pc,
  output logic [31:0] inst_masked,
  output logic [7:0]  pd_flags
);
  logic       adef, is_branch, is_jirl, is_bl, is_ld_w, is_st_w, wr_rd;
  logic       unused_pc_hi;

  assign unused_pc_hi = ^inst_pc[31:2];

  assign adef      = inst_pc[1:0] != 2'b00;
  assign is_branch = (inst[31:26] >= BR_OP_LO) && (inst[31:26] <= BR_OP_HI);
  assign is_jirl   = inst[31:26] == OP_JIRL;
  assign is_bl     = inst[31:26] == OP_BL;
  assign is_ld_w   = inst[31:22] == OP_LD_W;
  assign is_st_w   = inst[31:22] == OP_ST_W;
  // Link-writing branches (JIRL, BL) still write rd; other branches and stores do not.
  assign wr_rd     = ~(is_st_w | (is_branch & ~is_jirl & ~is_bl));

  always_comb begin
    pd_flags               = 8'h00;
    pd_flags[PD_ADEF]      = adef;
    pd_flags[PD_IS_BRANCH] = is_branch & ~adef;
    pd_flags[PD_IS_JIRL]   = is_jirl   & ~adef;
    pd_flags[PD_IS_BL]     = is_bl     & ~adef;
    pd_flags[PD_IS_LD_W]   = is_ld_w   & ~adef;
    pd_flags[PD_IS_ST_W]   = is_st_w   & ~adef;
    pd_flags[PD_WR_RD]     = wr_rd     & ~adef;
  end

  assign inst_masked = adef ? 32'h0 : inst;
endmodule

// File: rtl/ipd_stage.sv
// Inst pre-decode stage: holds the IF bundle, captures the RAM word across
// ID stalls and forwards it with pre-decode flags.
module ipd_stage
  import ipd_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC_BUS = 64'h0,
  parameter logic [5:0]  BR_OP_LO     = 6'h13,
  parameter logic [5:0]  BR_OP_HI     = 6'h1B
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
  input  logic                        IF_to_IPD_valid,
  output logic                        IPD_allow_in,
  input  logic [31:0]                 inst_ram_rdata,
  input  logic                        br_taken_cancel,
  input  logic                        ID_allow_in,
  output logic                        IPD_to_ID_valid,
  output logic [IPD_TO_ID_BUS_WD-1:0] IPD_to_ID_bus
);
  logic        ipd_valid, first_cycle, inst_buf_valid;
  logic [63:0] pc_bundle;
  logic [31:0] inst_buf, inst_raw, inst_masked;
  logic [7:0]  pd_flags;
  logic        ready_go, capture;
  ipd_to_id_t  out_bus;

  assign ready_go        = ipd_valid;
  // A redirect always frees the slot so the branch target can enter at once.
  assign IPD_allow_in    = ~ipd_valid | (ready_go & ID_allow_in) | br_taken_cancel;
  assign capture         = IPD_allow_in & IF_to_IPD_valid;
  assign IPD_to_ID_valid = ipd_valid & ~br_taken_cancel;

  always_ff @(posedge clk) begin
    if (reset) begin
      ipd_valid      <= 1'b0;
      pc_bundle      <= RESET_PC_BUS;
      first_cycle    <= 1'b0;
      inst_buf       <= 32'h0;
      inst_buf_valid <= 1'b0;
    end else if (capture) begin
      pc_bundle      <= IF_to_IPD_bus;
      ipd_valid      <= 1'b1;
      first_cycle    <= 1'b1;
      inst_buf_valid <= 1'b0;
    end else begin
      first_cycle <= 1'b0;
      if (IPD_allow_in) begin
        ipd_valid      <= 1'b0;
        inst_buf_valid <= 1'b0;
      end else if (ipd_valid & first_cycle & ~ID_allow_in) begin
        // RAM data is only guaranteed on the first held cycle; keep a copy.
        inst_buf       <= inst_ram_rdata;
        inst_buf_valid <= 1'b1;
      end
    end
  end

  assign inst_raw = inst_buf_valid ? inst_buf : inst_ram_rdata;

  ipd_predecode #(.BR_OP_LO(BR_OP_LO), .BR_OP_HI(BR_OP_HI)) u_predecode (
    .inst        (inst_raw),
    .inst_pc     (pc_bundle[31:0]),
    .inst_masked (inst_masked),
    .pd_flags    (pd_flags)
  );

  always_comb begin
    out_bus.pred_pc  = pc_bundle[63:32];
    out_bus.inst_pc  = pc_bundle[31:0];
    out_bus.inst     = inst_masked;
    out_bus.pd_flags = pd_flags;
  end

  assign IPD_to_ID_bus = out_bus;
endmodule

// File: tb/tb_ipd_stage.sv
// Directed bench for ipd_stage: capture, stall hold, flush, adef, streaming, reset.
module tb_ipd_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  IF_to_IPD_bus;
  logic         IF_to_IPD_valid;
  logic         IPD_allow_in;
  logic [31:0]  inst_ram_rdata;
  logic         br_taken_cancel;
  logic         ID_allow_in;
  logic         IPD_to_ID_valid;
  logic [103:0] IPD_to_ID_bus;

  int checks = 0;
  int failures = 0;

  logic [31:0] rd_tab [0:7] = '{32'h48000000, 32'h58000000, 32'h4C000000, 32'h54000000,
                                32'h28800000, 32'h29800000, 32'h6C000000, 32'h70000000};
  logic [7:0]  fl_tab [0:7] = '{8'h40, 8'h02, 8'h46, 8'h4A, 8'h50, 8'h20, 8'h02, 8'h40};

  ipd_stage dut (
    .clk             (clk),
    .reset           (reset),
    .IF_to_IPD_bus   (IF_to_IPD_bus),
    .IF_to_IPD_valid (IF_to_IPD_valid),
    .IPD_allow_in    (IPD_allow_in),
    .inst_ram_rdata  (inst_ram_rdata),
    .br_taken_cancel (br_taken_cancel),
    .ID_allow_in     (ID_allow_in),
    .IPD_to_ID_valid (IPD_to_ID_valid),
    .IPD_to_ID_bus   (IPD_to_ID_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic ai, input logic [103:0] bus);
    @(negedge clk);
    chk({tag, "_valid"}, {103'h0, IPD_to_ID_valid}, {103'h0, v});
    chk({tag, "_allow"}, {103'h0, IPD_allow_in}, {103'h0, ai});
    if (v) chk({tag, "_bus"}, IPD_to_ID_bus, bus);
  endtask

  function automatic logic [103:0] eb(input logic [31:0] pred, input logic [31:0] pc,
                                      input logic [31:0] inst, input logic [7:0] fl);
    return {pred, pc, inst, fl};
  endfunction

  initial begin
    reset = 1'b1; IF_to_IPD_bus = 64'h0; IF_to_IPD_valid = 1'b0;
    inst_ram_rdata = 32'h0; br_taken_cancel = 1'b0; ID_allow_in = 1'b1;
    tick(); tick();
    chk_out("reset", 1'b0, 1'b1, '0);
    tick();
    reset = 1'b0;

    // basic pass-through: addi-like word, wr_rd only
    IF_to_IPD_valid = 1'b1; IF_to_IPD_bus = {32'h1C000004, 32'h1C000000};
    tick();
    IF_to_IPD_valid = 1'b0; inst_ram_rdata = 32'h02800C0C;
    chk_out("basic", 1'b1, 1'b1, eb(32'h1C000004, 32'h1C000000, 32'h02800C0C, 8'h40));
    tick();
    chk_out("basic_drain", 1'b0, 1'b1, '0);

    // stall hold: RAM output changes while ID is blocked
    IF_to_IPD_valid = 1'b1; IF_to_IPD_bus = {32'h1C000008, 32'h1C000004};
    tick();
    IF_to_IPD_valid = 1'b0; inst_ram_rdata = 32'h58000C0D; ID_allow_in = 1'b0;
    chk_out("stall0", 1'b1, 1'b0, eb(32'h1C000008, 32'h1C000004, 32'h58000C0D, 8'h02));
    tick();
    inst_ram_rdata = 32'hFFFFFFFF;
    chk_out("stall1", 1'b1, 1'b0, eb(32'h1C000008, 32'h1C000004, 32'h58000C0D, 8'h02));
    tick();
    chk_out("stall2", 1'b1, 1'b0, eb(32'h1C000008, 32'h1C000004, 32'h58000C0D, 8'h02));
    tick();
    ID_allow_in = 1'b1;
    chk_out("release", 1'b1, 1'b1, eb(32'h1C000008, 32'h1C000004, 32'h58000C0D, 8'h02));
    tick();
    chk_out("release_once", 1'b0, 1'b1, '0);

    // flush with simultaneous redirect capture
    IF_to_IPD_valid = 1'b1; IF_to_IPD_bus = {32'h1C000014, 32'h1C000010};
    tick();
    IF_to_IPD_valid = 1'b0; inst_ram_rdata = 32'h4C000000; ID_allow_in = 1'b0;
    chk_out("fl_hold", 1'b1, 1'b0, eb(32'h1C000014, 32'h1C000010, 32'h4C000000, 8'h46));
    tick();
    inst_ram_rdata = 32'hFFFFFFFF;
    br_taken_cancel = 1'b1; IF_to_IPD_valid = 1'b1; IF_to_IPD_bus = {32'h1C000104, 32'h1C000100};
    chk_out("fl_cancel", 1'b0, 1'b1, '0);
    tick();
    br_taken_cancel = 1'b0; IF_to_IPD_valid = 1'b0; ID_allow_in = 1'b1;
    inst_ram_rdata = 32'h28800000;
    chk_out("fl_target", 1'b1, 1'b1, eb(32'h1C000104, 32'h1C000100, 32'h28800000, 8'h50));
    tick();

    // misaligned PC: instruction squashed, only adef set
    IF_to_IPD_valid = 1'b1; IF_to_IPD_bus = {32'h1C000008, 32'h1C000002};
    tick();
    IF_to_IPD_valid = 1'b0; inst_ram_rdata = 32'h58000C0D;
    chk_out("adef", 1'b1, 1'b1, eb(32'h1C000008, 32'h1C000002, 32'h0, 8'h01));
    tick();

    // back-to-back stream of 8 entries covering the decode classes
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        IF_to_IPD_valid = 1'b1;
        IF_to_IPD_bus = {32'h1C000300 + 32'(4 * i), 32'h1C000200 + 32'(4 * i)};
      end else begin
        IF_to_IPD_valid = 1'b0;
      end
      if (i > 0) begin
        inst_ram_rdata = rd_tab[i-1];
        chk_out($sformatf("stream%0d", i - 1), 1'b1, 1'b1,
                eb(32'h1C000300 + 32'(4 * (i - 1)), 32'h1C000200 + 32'(4 * (i - 1)),
                   rd_tab[i-1], fl_tab[i-1]));
      end
      tick();
    end
    chk_out("stream_end", 1'b0, 1'b1, '0);

    // reset while an entry is held with a filled buffer
    IF_to_IPD_valid = 1'b1; IF_to_IPD_bus = {32'h1C000404, 32'h1C000400};
    tick();
    IF_to_IPD_valid = 1'b0; inst_ram_rdata = 32'h58000000; ID_allow_in = 1'b0;
    tick();
    inst_ram_rdata = 32'hFFFFFFFF;
    tick();
    reset = 1'b1;
    tick();
    chk_out("rst_stall", 1'b0, 1'b1, '0);
    reset = 1'b0; ID_allow_in = 1'b1;
    IF_to_IPD_valid = 1'b1; IF_to_IPD_bus = {32'h1C000504, 32'h1C000500};
    tick();
    IF_to_IPD_valid = 1'b0; inst_ram_rdata = 32'h29800000;
    chk_out("rst_after", 1'b1, 1'b1, eb(32'h1C000504, 32'h1C000500, 32'h29800000, 8'h20));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ipd_stage.md
Name: ipd_stage

Overview:
- Second pipeline stage (inst pre-decode), between IF and ID.
- Captures the {pred_pc, inst_pc} bundle from IF. Collects the instruction word from the one-cycle-latency inst RAM.
- Holds that word stable across downstream stalls. Generates pre-decode flags.
- Forwards everything to ID under valid/allow_in handshake; drops wrong-path entries on branch cancel.

Parameters:
- RESET_PC_BUS, 64'h0, value loaded into the held PC bundle on reset.
- BR_OP_LO, 6'h13, lowest inst[31:26] opcode counted as branch/jump.
- BR_OP_HI, 6'h1B, highest inst[31:26] opcode counted as branch/jump.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- IF_to_IPD_bus  in  64  {pred_pc[63:32], inst_pc[31:0]}; inst_pc is the address presented to inst RAM this cycle
- IF_to_IPD_valid  in  1  IF holds a valid entry
- IPD_allow_in  out  1  IPD accepts an entry this cycle
- inst_ram_rdata  in  32  RAM read data for the address presented the previous cycle
- br_taken_cancel  in  1  ID redirect; kill the held entry
- ID_allow_in  in  1  ID accepts this cycle
- IPD_to_ID_valid  out  1  entry valid toward ID
- IPD_to_ID_bus  out  104  {pred_pc[103:72], inst_pc[71:40], inst[39:8], pd_flags[7:0]}

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- State registers:
  - ipd_valid
  - pc_bundle[63:0]
  - first_cycle (entry captured last cycle)
  - inst_buf[31:0]
  - inst_buf_valid
- Reset values: all registers 0 (pc_bundle = RESET_PC_BUS). IPD_to_ID_valid=0, IPD_allow_in=1.
- Handshake:
  - ready_go = ipd_valid.
  - IPD_allow_in = ~ipd_valid | (ready_go & ID_allow_in).
  - IPD_to_ID_valid = ipd_valid & ~br_taken_cancel.
- Capture: on IPD_allow_in & IF_to_IPD_valid, set pc_bundle <= IF_to_IPD_bus, ipd_valid <= 1, first_cycle <= 1, inst_buf_valid <= 0.
- Allow_in without a valid input: ipd_valid <= 0.
- Instruction select: inst = inst_buf_valid ? inst_buf : inst_ram_rdata. Latency is one cycle from capture to the instruction being visible.
- Stall hold: if ipd_valid & first_cycle & ~ID_allow_in, then inst_buf <= inst_ram_rdata and inst_buf_valid <= 1. first_cycle clears every cycle in which no new capture occurs. The RAM output may change after the first cycle; the buffer must be used from the second held cycle on.
- Flush: br_taken_cancel=1 kills the currently held entry.
  - ipd_valid <= 0 unless a capture happens the same cycle.
  - inst_buf_valid <= 0.
  - Output valid is masked combinationally in that cycle.
- Flush with simultaneous IF_to_IPD_valid: the incoming entry is the redirect target and IS captured. IPD_allow_in is forced to 1 while br_taken_cancel=1.
- pd_flags, all combinational on inst and inst_pc:
  - [0] adef = inst_pc[1:0]!=0
  - [1] is_branch = BR_OP_LO <= inst[31:26] <= BR_OP_HI
  - [2] is_jirl = inst[31:26]==6'h13
  - [3] is_bl = inst[31:26]==6'h15
  - [4] is_ld_w = inst[31:22]==10'h0A2
  - [5] is_st_w = inst[31:22]==10'h0A6
  - [6] wr_rd = ~(is_st_w | (is_branch & ~is_jirl & ~is_bl))
  - [7] reserved, 0
- When adef=1, inst is forced to 32'h0 and flags [6:1] to 0; adef still propagates.
- Back-to-back: pass-through throughput is one entry per cycle when ID_allow_in stays 1; no bubbles.
- Reset mid-stall: buffered instruction discarded; no output valid the cycle after reset.

Decomposition:
- Shared header (myCPU.h):
  - IF_TO_IPD_BUS_WD=64
  - IPD_TO_ID_BUS_WD=104
  - pd_flags bit index constants
  - opcode constants for JIRL/BL/LD.W/ST.W
- Sub-module ipd_predecode: purely combinational (inst, inst_pc) -> pd_flags, masked inst. Reused later by a branch predictor.

Test Plan:
- Reset, then capture inst_pc=0x1C000000 with rdata next cycle 0x02800C0C, ID_allow_in=1 -> valid one cycle after capture; bus inst=0x02800C0C, pd_flags=0x40.
- Capture 0x1C000004; next cycle rdata=0x58000C0D (BEQ); ID_allow_in=0 for 3 cycles while rdata changes to 0xFFFFFFFF -> inst holds 0x58000C0D; flags=0x02; allow_in=0 during stall; one transfer after release.
- Hold an entry stalled; assert br_taken_cancel with IF_to_IPD_valid=1, inst_pc=0x1C000100 -> same-cycle IPD_to_ID_valid=0; next cycle valid entry has inst_pc=0x1C000100, inst_buf_valid=0.
- inst_pc=0x1C000002 -> flags=0x01, inst=0.
- 8 consecutive captures with ID_allow_in=1 -> 8 outputs on consecutive cycles, in order, no drop or duplicate.
- Reset asserted during a stall -> next cycle IPD_to_ID_valid=0, IPD_allow_in=1, buffer cleared.
